// File: rtl/ring_decoder.sv
// One-hot ring code monitor: decodes the set bit to a binary index, checks that
// successive valid samples follow the ring rotation, and tracks lock and errors.
module ring_decoder #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8,
  localparam int IDX_W   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             ring_valid,
  output logic [IDX_W-1:0] index,
  output logic             index_valid,
  output logic             onehot_err,
  output logic             seq_err,
  output logic             lock,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [7:0]       LOCK_CNT_C = 8'(LOCK_CNT);
  localparam logic [WIDTH-1:0] ONE_W      = WIDTH'(1);

  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - ONE_W)) == '0);
  endfunction

  // OR-reduction of bit positions; only meaningful for one-hot inputs.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r = r | (v[i] ? IDX_W'(i) : '0);
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rotate(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [7:0]       good_cnt_q, good_cnt_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             index_valid_q, index_valid_d;
  logic             onehot_err_q, onehot_err_d;
  logic             seq_err_q, seq_err_d;
  logic             lock_q, lock_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             err_inc_s;
  logic             sample_ok_s;
  logic             match_s;

  assign sample_ok_s = is_onehot(ring_in);
  assign match_s     = (ring_in == expected_q);

  // Next-state decode for the lock FSM, pulses and error counter.
  always_comb begin
    state_d       = state_q;
    expected_d    = expected_q;
    good_cnt_d    = good_cnt_q;
    index_d       = index_q;
    lock_d        = lock_q;
    index_valid_d = 1'b0;
    onehot_err_d  = 1'b0;
    seq_err_d     = 1'b0;
    err_inc_s     = 1'b0;

    if (ring_valid) begin
      if (!sample_ok_s) begin
        onehot_err_d = 1'b1;
        err_inc_s    = 1'b1;
        state_d      = ST_SEARCH;
        lock_d       = 1'b0;
      end else begin
        index_d       = onehot_to_idx(ring_in);
        index_valid_d = 1'b1;
        expected_d    = rotate(ring_in);
        case (state_q)
          ST_SEARCH: begin
            state_d    = ST_VERIFY;
            good_cnt_d = 8'd0;
          end
          ST_VERIFY: begin
            // A mismatch here just re-seeds the reference without flagging.
            if (match_s) begin
              good_cnt_d = good_cnt_q + 8'd1;
              if ((good_cnt_q + 8'd1) == LOCK_CNT_C) begin
                state_d = ST_LOCKED;
                lock_d  = 1'b1;
              end else begin
                state_d = ST_VERIFY;
              end
            end else begin
              good_cnt_d = 8'd0;
            end
          end
          ST_LOCKED: begin
            if (match_s) begin
              state_d = ST_LOCKED;
            end else begin
              seq_err_d  = 1'b1;
              err_inc_s  = 1'b1;
              state_d    = ST_VERIFY;
              good_cnt_d = 8'd0;
              lock_d     = 1'b0;
            end
          end
          default: begin
            state_d    = ST_SEARCH;
            good_cnt_d = 8'd0;
            lock_d     = 1'b0;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end

    if (err_inc_s && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_W'(1);
    end else begin
      err_count_d = err_count_q;
    end
  end

  // State and registered outputs; reset clears all history at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_SEARCH;
      expected_q    <= '0;
      good_cnt_q    <= 8'd0;
      index_q       <= '0;
      index_valid_q <= 1'b0;
      onehot_err_q  <= 1'b0;
      seq_err_q     <= 1'b0;
      lock_q        <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      expected_q    <= expected_d;
      good_cnt_q    <= good_cnt_d;
      index_q       <= index_d;
      index_valid_q <= index_valid_d;
      onehot_err_q  <= onehot_err_d;
      seq_err_q     <= seq_err_d;
      lock_q        <= lock_d;
      err_count_q   <= err_count_d;
    end
  end

  assign index       = index_q;
  assign index_valid = index_valid_q;
  assign onehot_err  = onehot_err_q;
  assign seq_err     = seq_err_q;
  assign lock        = lock_q;
  assign err_count   = err_count_q;

endmodule
